// File: rtl/alu_execute_unit.sv
// Execute stage of the z8 core: accepts one decoded instruction, runs single-cycle
// or iterative (SHL, MUL) ops, commits through the register file write port.
module alu_execute_unit #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned SHAMT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           issue_op,
  input  logic [1:0]           issue_rd,
  input  logic [1:0]           issue_ra,
  input  logic [1:0]           issue_rb,
  output logic [1:0]           read_addr_a,
  output logic [1:0]           read_addr_b,
  input  logic [WORD_SIZE-1:0] read_data_a,
  input  logic [WORD_SIZE-1:0] read_data_b,
  output logic [1:0]           write_addr,
  output logic [WORD_SIZE-1:0] write_data,
  output logic                 write_enable,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 busy
);

  localparam int unsigned CW = SHAMT_BITS + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6, OP_MOV = 3'd7
  } op_t;

  state_t               state;
  op_t                  op;
  logic [1:0]           rd, ra, rb;
  logic [WORD_SIZE-1:0] a, b, acc;
  logic [CW-1:0]        cnt;
  logic                 carry;

  logic [WORD_SIZE:0]   add_sum, sub_diff, mul_sum;
  logic                 exec_done;
  logic [WORD_SIZE-1:0] exec_res;
  logic                 exec_carry;

  assign issue_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign read_addr_a = (state == IDLE) ? issue_ra : ra;
  assign read_addr_b = (state == IDLE) ? issue_rb : rb;

  // MUL keeps the product high half in acc and shifts the low half into b (LSB first)
  always_comb begin
    add_sum    = {1'b0, a} + {1'b0, b};
    sub_diff   = {1'b0, a} - {1'b0, b};
    mul_sum    = {1'b0, acc} + (b[0] ? {1'b0, a} : '0);
    exec_done  = 1'b1;
    exec_res   = a;
    exec_carry = 1'b0;
    case (op)
      OP_ADD: begin
        exec_res   = add_sum[WORD_SIZE-1:0];
        exec_carry = add_sum[WORD_SIZE];
      end
      OP_SUB: begin
        exec_res   = sub_diff[WORD_SIZE-1:0];
        exec_carry = sub_diff[WORD_SIZE];
      end
      OP_AND: exec_res = a & b;
      OP_OR:  exec_res = a | b;
      OP_XOR: exec_res = a ^ b;
      OP_SHL: begin
        // Last shift step commits directly, so only the final shifted-out bit is kept
        exec_done  = (cnt <= CW'(1));
        exec_res   = (cnt == '0) ? a : (a << 1);
        exec_carry = (cnt == '0) ? 1'b0 : a[WORD_SIZE-1];
      end
      OP_MUL: begin
        exec_done  = (cnt == CW'(1));
        exec_res   = {mul_sum[0], b[WORD_SIZE-1:1]};
        exec_carry = (mul_sum[WORD_SIZE:1] != '0);
      end
      default: exec_res = a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op           <= OP_ADD;
      rd           <= '0;
      ra           <= '0;
      rb           <= '0;
      a            <= '0;
      b            <= '0;
      acc          <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            op    <= op_t'(issue_op);
            rd    <= issue_rd;
            ra    <= issue_ra;
            rb    <= issue_rb;
            a     <= read_data_a;
            b     <= read_data_b;
            acc   <= '0;
            cnt   <= (op_t'(issue_op) == OP_SHL) ? {1'b0, read_data_b[SHAMT_BITS-1:0]}
                                                  : CW'(WORD_SIZE);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_SHL && cnt != '0) begin
            a   <= a << 1;
            cnt <= cnt - CW'(1);
          end
          if (op == OP_MUL) begin
            acc <= mul_sum[WORD_SIZE:1];
            b   <= {mul_sum[0], b[WORD_SIZE-1:1]};
            cnt <= cnt - CW'(1);
          end
          if (exec_done) begin
            write_data   <= exec_res;
            write_addr   <= rd;
            carry        <= exec_carry;
            write_enable <= 1'b1;
            state        <= WRITE;
          end
        end
        WRITE: begin
          write_enable <= 1'b0;
          flag_zero    <= (write_data == '0);
          flag_carry   <= carry;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit: behavioural register file, scoreboard of
// expected commits (data, flags, latency) checked when the DUT writes back.
module tb_alu_execute_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_op;
  logic [1:0]  issue_rd, issue_ra, issue_rb;
  logic [1:0]  read_addr_a, read_addr_b, write_addr;
  logic [15:0] read_data_a, read_data_b, write_data;
  logic        write_enable, flag_zero, flag_carry, busy;

  logic [15:0] rf [4];
  logic        pre_we = 1'b0;
  logic [1:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  typedef struct {
    logic [1:0]  rd;
    logic [15:0] data;
    logic        zero;
    logic        carry;
    int          hs;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  alu_execute_unit #(.WORD_SIZE(16), .SHAMT_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (write_enable) rf[write_addr] <= write_data;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end
  assign read_data_a = rf[read_addr_a];
  assign read_data_b = rf[read_addr_b];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [1:0] rd,
                                 input logic [15:0] a, input logic [15:0] b, input int hs);
    exp_t e;
    logic [16:0] s;
    logic [31:0] p;
    int sh;
    e.rd = rd; e.hs = hs; e.lat = 2; e.carry = 1'b0; e.data = a;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[15:0]; e.carry = s[16]; end
      3'd1: begin e.data = a - b; e.carry = (a < b); end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = a ^ b;
      3'd5: begin
        sh = int'(b[3:0]);
        e.data = a << sh;
        e.carry = (sh == 0) ? 1'b0 : a[16-sh];
        e.lat = (sh == 0) ? 2 : sh + 1;
      end
      3'd6: begin
        p = {16'h0, a} * {16'h0, b};
        e.data = p[15:0]; e.carry = |p[31:16]; e.lat = 17;
      end
      default: e.data = a;
    endcase
    e.zero = (e.data == 16'h0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (write_enable && !reset) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {31'b0, write_enable}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("write_addr", {30'b0, write_addr}, {30'b0, e.rd});
        check("write_data", {16'b0, write_data}, {16'b0, e.data});
        check("latency", cyc + 1 - e.hs, e.lat);
        @(negedge clk);
        if (!reset) begin
          check("flag_zero", {31'b0, flag_zero}, {31'b0, e.zero});
          check("flag_carry", {31'b0, flag_carry}, {31'b0, e.carry});
        end
      end
    end
  end

  task automatic preload(input logic [1:0] addr, input logic [15:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input bit hold);
    @(negedge clk);
    issue_valid = 1'b1; issue_op = op; issue_rd = rd; issue_ra = ra; issue_rb = rb;
    for (int i = 0; i < 200; i++) begin
      if (issue_ready) break;
      @(negedge clk);
    end
    check("issue_accept", {31'b0, issue_ready}, 32'd1);
    sb.push_back(model(op, rd, rf[ra], rf[rb], cyc + 1));
    @(posedge clk);
    #1;
    if (!hold) issue_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && issue_ready) break;
    end
    check("drain", {31'b0, (sb.size() == 0) && issue_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_op = '0; issue_rd = '0; issue_ra = '0; issue_rb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, issue_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_we", {31'b0, write_enable}, 32'd0);
    check("rst_flags", {30'b0, flag_zero, flag_carry}, 32'd0);
    reset = 1'b0;

    preload(2'd1, 16'hFFFF); preload(2'd2, 16'h0001);
    issue(3'd0, 2'd0, 2'd1, 2'd2, 1'b0); drain();

    preload(2'd1, 16'h0003); preload(2'd2, 16'h0005);
    issue(3'd1, 2'd3, 2'd1, 2'd2, 1'b0); drain();

    preload(2'd1, 16'h8001); preload(2'd2, 16'h0004);
    issue(3'd5, 2'd1, 2'd1, 2'd2, 1'b0); drain();
    preload(2'd1, 16'h8001); preload(2'd2, 16'h0001);
    issue(3'd5, 2'd1, 2'd1, 2'd2, 1'b0); drain();
    preload(2'd1, 16'h8001); preload(2'd2, 16'h0010);
    issue(3'd5, 2'd0, 2'd1, 2'd2, 1'b0); drain();

    preload(2'd1, 16'hF0F0); preload(2'd2, 16'h3C3C);
    issue(3'd2, 2'd0, 2'd1, 2'd2, 1'b0); drain();
    issue(3'd3, 2'd0, 2'd1, 2'd2, 1'b0); drain();
    issue(3'd4, 2'd3, 2'd1, 2'd2, 1'b0); drain();

    preload(2'd1, 16'h0123); preload(2'd2, 16'h0045);
    issue(3'd6, 2'd1, 2'd1, 2'd2, 1'b0); drain();

    preload(2'd1, 16'h0100); preload(2'd2, 16'h0100);
    issue(3'd6, 2'd2, 2'd1, 2'd2, 1'b0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("mul_ready_low", {31'b0, issue_ready}, 32'd0);
    end
    drain();

    // Reset mid-MUL: nothing in flight may reach the register file
    preload(2'd3, 16'h7777); preload(2'd1, 16'h0123); preload(2'd2, 16'h0045);
    issue(3'd6, 2'd3, 2'd1, 2'd2, 1'b0);
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_mul_we", {31'b0, write_enable}, 32'd0);
    check("mid_mul_ready", {31'b0, issue_ready}, 32'd1);
    check("mid_mul_busy", {31'b0, busy}, 32'd0);
    check("mid_mul_flags", {30'b0, flag_zero, flag_carry}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_mul_no_write", {16'b0, rf[3]}, 32'h7777);

    // Reset while write_enable is high: strobe must drop before the commit edge
    preload(2'd0, 16'h5555); preload(2'd1, 16'h0001); preload(2'd2, 16'h0002);
    issue(3'd0, 2'd0, 2'd1, 2'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_enable) break;
    end
    check("write_seen", {31'b0, write_enable}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_write_we", {31'b0, write_enable}, 32'd0);
    check("mid_write_ready", {31'b0, issue_ready}, 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    check("mid_write_no_write", {16'b0, rf[0]}, 32'h5555);
    reset = 1'b0;

    preload(2'd1, 16'h1234);
    issue(3'd7, 2'd0, 2'd1, 2'd1, 1'b1);
    issue(3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drain();
    check("b2b_r0", {16'b0, rf[0]}, 32'h2468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
